cuckoo_insert_controller: RTL and testbench
===========================================

CUCKOO_INSERT_CONTROLLER -- requirements
Module: cuckoo_insert_controller

Interface
REQ-001 Parameters (name, default, meaning), all SHALL exist as follows:
  DATA_WIDTH, 4, value bits; KEY_WIDTH, 2, key bits; NUMBER_OF_TABLES (T), 3, cuckoo tables;
  MAX_HASH_ADR_WIDTH, 2, table address bits; READ_LATENCY (L), 2, table read latency in cycles, >=1; MAX_KICKS, 4, evictions allowed per insert.
REQ-002 Ports (name, direction, width, meaning):
  clk in 1 clock; reset in 1 async active-high reset; clk_en in 1 global enable;
  req_valid_i in 1, req_ready_o out 1, req_key_i in KEY_WIDTH, req_data_i in DATA_WIDTH: insert request;
  hash_key_o out KEY_WIDTH, key presented to hash units; hash_adr_i in MAX_HASH_ADR_WIDTH x T, combinational hash of hash_key_o;
  rd_en_o out 1 x T, rd_adr_o out MAX_HASH_ADR_WIDTH x T: table reads;
  rd_key_i in KEY_WIDTH x T, rd_data_i in DATA_WIDTH x T, rd_valid_i in 1 x T: read data, valid L cycles after rd_en_o;
  wr_en_o out 1 x T, wr_adr_o out MAX_HASH_ADR_WIDTH, wr_key_o out KEY_WIDTH, wr_data_o out DATA_WIDTH, wr_valid_o out 1: table write;
  resp_valid_o out 1, resp_status_o out 1 (0 OK, 1 FAIL), resp_key_o out KEY_WIDTH, resp_data_o out DATA_WIDTH: completion.
REQ-003 One clock; reset is asynchronous and active-high; ports named clk and reset.

Function
REQ-004 FSM states IDLE, READ, WAIT, CHECK, WRITE, RESP; all state, counters and outputs SHALL freeze while clk_en=0, with rd_en_o/wr_en_o/resp_valid_o forced 0.
REQ-005 req_ready_o SHALL be 1 only in IDLE; handshake at edge A latches key/data into cur pair, kick_cnt=0, victim ptr=0, goes to READ.
REQ-006 READ (cycle A+1): hash_key_o=cur key, rd_en_o all 1 for one cycle, rd_adr_o[t]=hash_adr_i[t], addresses also registered per table.
REQ-007 WAIT lasts L-1 cycles (skipped when L=1); CHECK samples rd_* in cycle A+L+1.
REQ-008 CHECK priority: (1) lowest t with rd_valid_i[t] and rd_key_i[t]==cur key -> overwrite, final; (2) lowest t with rd_valid_i[t]=0 -> write, final; (3) all full, kick_cnt<MAX_KICKS -> evict table victim ptr; (4) all full, kick_cnt==MAX_KICKS -> no write, RESP with FAIL.
REQ-009 WRITE: exactly one wr_en_o[t]=1 for one cycle, wr_adr_o=registered address of t, wr_key_o/wr_data_o=cur pair, wr_valid_o=1.
REQ-010 Eviction: old rd_key/rd_data of victim become cur pair, kick_cnt+1, victim ptr=(ptr+1) mod T, FSM returns to READ after WRITE; each kick adds L+2 cycles.
REQ-011 RESP: resp_valid_o one-cycle pulse, no backpressure; OK -> resp_key/data = originally requested pair; FAIL -> unplaced cur pair; then IDLE.
REQ-012 No-kick insert: resp_valid_o high in cycle A+L+3; next request acceptable at A+L+4.
REQ-013 Requests presented while busy SHALL be held off (ready=0), never dropped.

Reset
REQ-014 reset SHALL immediately force IDLE, kick_cnt=0, victim ptr=0 and every output 0 except req_ready_o=1 (after release); an in-flight insert is abandoned with no response.

Structure
REQ-015 Shared package hash_pkg SHALL hold the FSM state enum and the resp status enum (OK/FAIL).
REQ-016 Sub-module cuckoo_victim_rr (round-robin victim pointer, mod T, clear and advance inputs) SHALL be instantiated; rest flat.

Verification (T=3, L=2, MAX_KICKS=4)
REQ-017 Empty tables, insert key 1 data 5 -> wr_en_o=001, resp OK key1 data5 at A+5.
REQ-018 Table1 holds key 2 at hash addr, insert key 2 data 9 -> wr_en_o=010 overwrite, data 9, OK.
REQ-019 Tables 0,1 full, 2 empty -> wr_en_o=100, no eviction, OK at A+5.
REQ-020 All full on every read -> 4 evictions to tables 0,1,2,0 then FAIL with 4th evicted pair, resp at A+5+4*4.
REQ-021 clk_en low 3 cycles in WAIT -> response delayed exactly 3 cycles; reset asserted in WRITE -> wr_en_o=0 immediately, no resp_valid_o, req_ready_o=1 after release.

Source files
------------

// File: rtl/hash_pkg.sv
// Shared types for the cuckoo insert controller: FSM states, response
// status, the decision taken in CHECK and a small width helper.
package hash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    CHECK,
    WRITE,
    RESP
  } state_t;

  typedef enum logic {
    STATUS_OK   = 1'b0,
    STATUS_FAIL = 1'b1
  } status_t;

  // What the WRITE state does with the decision latched in CHECK.
  typedef enum logic [1:0] {
    ACT_PLACE,   // hit or empty slot: final write, then respond OK
    ACT_EVICT,   // table full: write cur pair over victim, retry with victim pair
    ACT_GIVE_UP  // kick budget exhausted: no write, respond FAIL
  } action_t;

  // Bits needed to index n items; never below 1 so vectors stay legal.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cuckoo_victim_rr.sv
// Round-robin victim table pointer, counts 0..N-1 and wraps.
module cuckoo_victim_rr
  import hash_pkg::*;
#(
  parameter int unsigned N = 3,
  localparam int unsigned W = idx_width(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clk_en,
  input  logic         clear,
  input  logic         advance,
  output logic [W-1:0] ptr
);

  // Clear wins over advance; both only act while the global enable is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (clk_en) begin
      if (clear) begin
        ptr <= '0;
      end else if (advance) begin
        ptr <= (ptr == W'(N - 1)) ? '0 : ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cuckoo_insert_controller.sv
// Cuckoo hash insert controller: reads all tables at the key's hash
// addresses, then overwrites a matching key, fills the first empty slot,
// or evicts a round-robin victim and retries with the displaced pair.
module cuckoo_insert_controller
  import hash_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = 4,
  parameter int unsigned KEY_WIDTH          = 2,
  parameter int unsigned NUMBER_OF_TABLES   = 3,
  parameter int unsigned MAX_HASH_ADR_WIDTH = 2,
  parameter int unsigned READ_LATENCY       = 2,
  parameter int unsigned MAX_KICKS          = 4
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         clk_en,
  input  logic                                         req_valid_i,
  output logic                                         req_ready_o,
  input  logic [KEY_WIDTH-1:0]                         req_key_i,
  input  logic [DATA_WIDTH-1:0]                        req_data_i,
  output logic [KEY_WIDTH-1:0]                         hash_key_o,
  input  logic [NUMBER_OF_TABLES*MAX_HASH_ADR_WIDTH-1:0] hash_adr_i,
  output logic [NUMBER_OF_TABLES-1:0]                  rd_en_o,
  output logic [NUMBER_OF_TABLES*MAX_HASH_ADR_WIDTH-1:0] rd_adr_o,
  input  logic [NUMBER_OF_TABLES*KEY_WIDTH-1:0]        rd_key_i,
  input  logic [NUMBER_OF_TABLES*DATA_WIDTH-1:0]       rd_data_i,
  input  logic [NUMBER_OF_TABLES-1:0]                  rd_valid_i,
  output logic [NUMBER_OF_TABLES-1:0]                  wr_en_o,
  output logic [MAX_HASH_ADR_WIDTH-1:0]                wr_adr_o,
  output logic [KEY_WIDTH-1:0]                         wr_key_o,
  output logic [DATA_WIDTH-1:0]                        wr_data_o,
  output logic                                         wr_valid_o,
  output logic                                         resp_valid_o,
  output logic                                         resp_status_o,
  output logic [KEY_WIDTH-1:0]                         resp_key_o,
  output logic [DATA_WIDTH-1:0]                        resp_data_o
);

  localparam int unsigned T   = NUMBER_OF_TABLES;
  localparam int unsigned AW  = MAX_HASH_ADR_WIDTH;
  localparam int unsigned KW  = KEY_WIDTH;
  localparam int unsigned DW  = DATA_WIDTH;
  localparam int unsigned TW  = idx_width(T);
  localparam int unsigned KCW = idx_width(MAX_KICKS + 1);
  localparam int unsigned WCW = idx_width(READ_LATENCY);

  state_t          state, state_nx;
  logic [KW-1:0]   cur_key, orig_key, evk_key, vic_key;
  logic [DW-1:0]   cur_data, orig_data, evk_data, vic_data;
  logic [KCW-1:0]  kick_cnt;
  logic [WCW-1:0]  wait_cnt;
  logic [AW-1:0]   adr_q [T];
  logic [TW-1:0]   victim, tgt_q, hit_idx, emp_idx, chk_tgt;
  logic            hit_found, emp_found, wait_done, accept, evicting;
  action_t         act_q, chk_act;

  assign accept    = (state == IDLE) && clk_en && req_valid_i;
  assign evicting  = (state == WRITE) && (act_q == ACT_EVICT);
  assign wait_done = (wait_cnt == WCW'(READ_LATENCY - 2));

  cuckoo_victim_rr #(
    .N(T)
  ) u_victim_rr (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .clear  (accept),
    .advance(evicting),
    .ptr    (victim)
  );

  // State register, frozen while the global enable is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (clk_en) begin
      state <= state_nx;
    end
  end

  // CHECK decision: matching key first, then first empty slot, then evict or give up.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = '0;
    emp_found = 1'b0;
    emp_idx   = '0;
    vic_key   = '0;
    vic_data  = '0;
    for (int unsigned t = 0; t < T; t++) begin
      if (!hit_found && rd_valid_i[t] && (rd_key_i[t*KW +: KW] == cur_key)) begin
        hit_found = 1'b1;
        hit_idx   = TW'(t);
      end
      if (!emp_found && !rd_valid_i[t]) begin
        emp_found = 1'b1;
        emp_idx   = TW'(t);
      end
      if (victim == TW'(t)) begin
        vic_key  = rd_key_i[t*KW +: KW];
        vic_data = rd_data_i[t*DW +: DW];
      end
    end
    if (hit_found) begin
      chk_act = ACT_PLACE;
      chk_tgt = hit_idx;
    end else if (emp_found) begin
      chk_act = ACT_PLACE;
      chk_tgt = emp_idx;
    end else if (kick_cnt < KCW'(MAX_KICKS)) begin
      chk_act = ACT_EVICT;
      chk_tgt = victim;
    end else begin
      chk_act = ACT_GIVE_UP;
      chk_tgt = '0;
    end
  end

  // Next state and all table/response outputs; strobes are masked while disabled.
  always_comb begin
    state_nx      = state;
    req_ready_o   = 1'b0;
    hash_key_o    = cur_key;
    rd_en_o       = '0;
    rd_adr_o      = '0;
    wr_en_o       = '0;
    wr_adr_o      = '0;
    wr_key_o      = '0;
    wr_data_o     = '0;
    wr_valid_o    = 1'b0;
    resp_valid_o  = 1'b0;
    resp_status_o = STATUS_OK;
    resp_key_o    = '0;
    resp_data_o   = '0;
    case (state)
      IDLE: begin
        req_ready_o = clk_en;
        if (req_valid_i) state_nx = READ;
      end
      READ: begin
        rd_en_o  = '1;
        rd_adr_o = hash_adr_i;
        state_nx = (READ_LATENCY > 1) ? WAIT : CHECK;
      end
      WAIT: begin
        if (wait_done) state_nx = CHECK;
      end
      CHECK: begin
        state_nx = WRITE;
      end
      WRITE: begin
        // The give-up path still spends this cycle so a failed insert
        // keeps the same per-attempt cadence as a successful one.
        if (act_q != ACT_GIVE_UP) begin
          for (int unsigned t = 0; t < T; t++) begin
            if (tgt_q == TW'(t)) begin
              wr_en_o[t] = 1'b1;
              wr_adr_o   = adr_q[t];
            end
          end
          wr_key_o   = cur_key;
          wr_data_o  = cur_data;
          wr_valid_o = 1'b1;
        end
        state_nx = (act_q == ACT_EVICT) ? READ : RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        if (act_q == ACT_GIVE_UP) begin
          resp_status_o = STATUS_FAIL;
          resp_key_o    = cur_key;
          resp_data_o   = cur_data;
        end else begin
          resp_status_o = STATUS_OK;
          resp_key_o    = orig_key;
          resp_data_o   = orig_data;
        end
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (!clk_en) begin
      rd_en_o      = '0;
      wr_en_o      = '0;
      resp_valid_o = 1'b0;
    end
  end

  // Datapath registers: current/original pair, kick and wait counters, latched decision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_key   <= '0;
      cur_data  <= '0;
      orig_key  <= '0;
      orig_data <= '0;
      evk_key   <= '0;
      evk_data  <= '0;
      kick_cnt  <= '0;
      wait_cnt  <= '0;
      tgt_q     <= '0;
      act_q     <= ACT_PLACE;
      for (int unsigned t = 0; t < T; t++) adr_q[t] <= '0;
    end else if (clk_en) begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            cur_key   <= req_key_i;
            cur_data  <= req_data_i;
            orig_key  <= req_key_i;
            orig_data <= req_data_i;
            kick_cnt  <= '0;
          end
        end
        READ: begin
          for (int unsigned t = 0; t < T; t++) adr_q[t] <= hash_adr_i[t*AW +: AW];
          wait_cnt <= '0;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
        end
        CHECK: begin
          act_q    <= chk_act;
          tgt_q    <= chk_tgt;
          evk_key  <= vic_key;
          evk_data <= vic_data;
        end
        WRITE: begin
          if (act_q == ACT_EVICT) begin
            cur_key  <= evk_key;
            cur_data <= evk_data;
            kick_cnt <= kick_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cuckoo_insert_controller.sv
// Self-checking bench: behavioural table memory around the DUT plus a
// reference cuckoo-insert model working directly on table arrays.
module tb_cuckoo_insert_controller;

  localparam int DW = 4;
  localparam int KW = 2;
  localparam int T  = 3;
  localparam int AW = 2;
  localparam int L  = 2;
  localparam int MK = 4;
  localparam int NA = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clk_en = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [KW-1:0] req_key = '0;
  logic [DW-1:0] req_data = '0;
  logic [KW-1:0] hash_key;
  logic [T*AW-1:0] hash_adr;
  logic [T-1:0] rd_en;
  logic [T*AW-1:0] rd_adr;
  logic [T*KW-1:0] rd_key = '0;
  logic [T*DW-1:0] rd_data = '0;
  logic [T-1:0] rd_valid = '0;
  logic [T-1:0] wr_en;
  logic [AW-1:0] wr_adr;
  logic [KW-1:0] wr_key;
  logic [DW-1:0] wr_data;
  logic wr_valid, resp_valid, resp_status;
  logic [KW-1:0] resp_key;
  logic [DW-1:0] resp_data;

  cuckoo_insert_controller #(
    .DATA_WIDTH(DW), .KEY_WIDTH(KW), .NUMBER_OF_TABLES(T),
    .MAX_HASH_ADR_WIDTH(AW), .READ_LATENCY(L), .MAX_KICKS(MK)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_key_i(req_key), .req_data_i(req_data),
    .hash_key_o(hash_key), .hash_adr_i(hash_adr),
    .rd_en_o(rd_en), .rd_adr_o(rd_adr),
    .rd_key_i(rd_key), .rd_data_i(rd_data), .rd_valid_i(rd_valid),
    .wr_en_o(wr_en), .wr_adr_o(wr_adr), .wr_key_o(wr_key),
    .wr_data_o(wr_data), .wr_valid_o(wr_valid),
    .resp_valid_o(resp_valid), .resp_status_o(resp_status),
    .resp_key_o(resp_key), .resp_data_o(resp_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Hash units: mode 0 spreads keys, mode 1 maps everything to address 0, mode 2 uses key bit 0.
  int hash_mode = 0;
  function automatic logic [AW-1:0] hfn(input int mode, input int t, input logic [KW-1:0] k);
    int v;
    if (mode == 1) return '0;
    if (mode == 2) return AW'(int'(k) % 2);
    v = (int'(k) * (t + 1) + t) % NA;
    return AW'(v);
  endfunction

  always_comb begin
    hash_adr = '0;
    for (int t = 0; t < T; t++) hash_adr[t*AW +: AW] = hfn(hash_mode, t, hash_key);
  end

  // Table memory seen by the DUT and the reference copy used by the model.
  logic [KW-1:0] mem_k [T][NA];
  logic [DW-1:0] mem_d [T][NA];
  logic          mem_v [T][NA];
  logic [KW-1:0] ref_k [T][NA];
  logic [DW-1:0] ref_d [T][NA];
  logic          ref_v [T][NA];

  logic [T-1:0]    pv [L] = '{default: '0};
  logic [T*KW-1:0] pk [L] = '{default: '0};
  logic [T*DW-1:0] pd [L] = '{default: '0};

  logic [T-1:0]    s_rd_en = '0, s_wr_en = '0;
  logic [T*AW-1:0] s_rd_adr = '0;
  logic [AW-1:0]   s_wr_adr = '0;
  logic [KW-1:0]   s_wr_key = '0;
  logic [DW-1:0]   s_wr_data = '0;
  logic            s_en = 1'b0;

  // Sample table controls late in each cycle (inputs only change at negedge).
  always begin
    @(negedge clk);
    #1;
    s_rd_en = rd_en; s_rd_adr = rd_adr; s_wr_en = wr_en; s_wr_adr = wr_adr;
    s_wr_key = wr_key; s_wr_data = wr_data; s_en = clk_en;
  end

  // Memory clock edge: apply writes, then launch reads through an L-deep pipe.
  always begin
    logic [T-1:0] v0;
    logic [T*KW-1:0] k0;
    logic [T*DW-1:0] d0;
    logic [AW-1:0] a;
    @(posedge clk);
    #1;
    if (s_en && !reset) begin
      for (int t = 0; t < T; t++) begin
        if (s_wr_en[t]) begin
          mem_v[t][s_wr_adr] = 1'b1;
          mem_k[t][s_wr_adr] = s_wr_key;
          mem_d[t][s_wr_adr] = s_wr_data;
        end
      end
      v0 = '0; k0 = '0; d0 = '0;
      for (int t = 0; t < T; t++) begin
        if (s_rd_en[t]) begin
          a = s_rd_adr[t*AW +: AW];
          v0[t] = mem_v[t][a];
          k0[t*KW +: KW] = mem_k[t][a];
          d0[t*DW +: DW] = mem_d[t][a];
        end
      end
      for (int s = L - 1; s > 0; s--) begin
        pv[s] = pv[s-1]; pk[s] = pk[s-1]; pd[s] = pd[s-1];
      end
      pv[0] = v0; pk[0] = k0; pd[0] = d0;
    end
    rd_valid = pv[L-1];
    rd_key   = pk[L-1];
    rd_data  = pd[L-1];
  end

  task automatic clear_tables();
    for (int t = 0; t < T; t++) begin
      for (int a = 0; a < NA; a++) begin
        mem_v[t][a] = 1'b0; mem_k[t][a] = '0; mem_d[t][a] = '0;
        ref_v[t][a] = 1'b0; ref_k[t][a] = '0; ref_d[t][a] = '0;
      end
    end
  endtask

  task automatic put(input int t, input int a, input logic [KW-1:0] k, input logic [DW-1:0] d);
    mem_v[t][a] = 1'b1; mem_k[t][a] = k; mem_d[t][a] = d;
    ref_v[t][a] = 1'b1; ref_k[t][a] = k; ref_d[t][a] = d;
  endtask

  function automatic int table_diff();
    int n = 0;
    for (int t = 0; t < T; t++) begin
      for (int a = 0; a < NA; a++) begin
        if (mem_v[t][a] !== ref_v[t][a]) n++;
        else if (ref_v[t][a] && (mem_k[t][a] !== ref_k[t][a] || mem_d[t][a] !== ref_d[t][a])) n++;
      end
    end
    return n;
  endfunction

  // Reference cuckoo insert: outcome, response pair, cycle of the response, tables written.
  logic [T-1:0] exp_wr [$];
  task automatic model_insert(input logic [KW-1:0] k, input logic [DW-1:0] d,
                              output logic est, output logic [KW-1:0] ek,
                              output logic [DW-1:0] ed, output int elat);
    logic [KW-1:0] ck, ok;
    logic [DW-1:0] cd, od;
    logic [AW-1:0] a;
    int hit, emp, v;
    exp_wr.delete();
    ck = k; cd = d; est = 1'b0; ek = k; ed = d; elat = 0;
    for (int kick = 0; kick <= MK; kick++) begin
      hit = -1; emp = -1;
      for (int t = 0; t < T; t++) begin
        a = hfn(hash_mode, t, ck);
        if (hit < 0 && ref_v[t][a] && ref_k[t][a] == ck) hit = t;
        if (emp < 0 && !ref_v[t][a]) emp = t;
      end
      elat = L + 3 + kick * (L + 2);
      if (hit >= 0 || emp >= 0) begin
        v = (hit >= 0) ? hit : emp;
        a = hfn(hash_mode, v, ck);
        ref_v[v][a] = 1'b1; ref_k[v][a] = ck; ref_d[v][a] = cd;
        exp_wr.push_back(T'(1 << v));
        est = 1'b0; ek = k; ed = d;
        return;
      end
      if (kick == MK) begin
        est = 1'b1; ek = ck; ed = cd;
        return;
      end
      v = kick % T;
      a = hfn(hash_mode, v, ck);
      ok = ref_k[v][a]; od = ref_d[v][a];
      ref_k[v][a] = ck; ref_d[v][a] = cd;
      exp_wr.push_back(T'(1 << v));
      ck = ok; cd = od;
    end
  endtask

  task automatic wait_ready(output logic ok);
    int w = 0;
    do begin
      @(negedge clk);
      #1;
      w++;
    end while (!req_ready && w < 50);
    ok = req_ready;
    check_eq("ready_wait", 32'(req_ready), 32'd1);
  endtask

  // One insert through the DUT; optional clk_en stall starting at cycle A+stall_at.
  task automatic do_insert(input logic [KW-1:0] k, input logic [DW-1:0] d,
                           input int stall_at, input int stall_len);
    logic est, ok, gst;
    logic [KW-1:0] ek, gk;
    logic [DW-1:0] ed, gd;
    logic [T-1:0] got_wr [$];
    int elat, got, busy_rdy;
    model_insert(k, d, est, ek, ed, elat);
    elat += stall_len;
    wait_ready(ok);
    if (!ok) return;
    req_valid = 1'b1; req_key = k; req_data = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_key = KW'($urandom); req_data = DW'($urandom);
    got = 0; busy_rdy = 0; gst = 1'b0; gk = '0; gd = '0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (stall_len > 0 && n == stall_at) clk_en = 1'b0;
      if (stall_len > 0 && n == stall_at + stall_len) clk_en = 1'b1;
      #1;
      if (wr_en != '0) got_wr.push_back(wr_en);
      if (req_ready) busy_rdy++;
      if (resp_valid) begin
        got = n; gst = resp_status; gk = resp_key; gd = resp_data;
        break;
      end
    end
    clk_en = 1'b1;
    check_eq("resp_seen", 32'(got != 0), 32'd1);
    check_eq("resp_latency", 32'(got), 32'(elat));
    check_eq("resp_status", 32'(gst), 32'(est));
    check_eq("resp_key", 32'(gk), 32'(ek));
    check_eq("resp_data", 32'(gd), 32'(ed));
    check_eq("busy_ready", 32'(busy_rdy), 32'd0);
    check_eq("write_count", 32'(got_wr.size()), 32'(exp_wr.size()));
    for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
      check_eq($sformatf("wr_en_%0d", i), 32'(got_wr[i]), 32'(exp_wr[i]));
    @(negedge clk);
    #1;
    check_eq("ready_after_resp", 32'(req_ready), 32'd1);
    check_eq("tables", 32'(table_diff()), 32'd0);
  endtask

  // Reset while the DUT is writing: strobe drops at once, no response, write lost.
  task automatic reset_in_write();
    logic ok;
    int found, resp_cnt, rdy_bad;
    clear_tables();
    hash_mode = 0;
    wait_ready(ok);
    if (!ok) return;
    req_valid = 1'b1; req_key = 2'd3; req_data = 4'd7;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    found = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      #1;
      if (wr_en != '0) begin
        found = 1;
        break;
      end
    end
    check_eq("rst_reach_write", 32'(found), 32'd1);
    check_eq("rst_wr_en_before", 32'(wr_en), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check_eq("rst_wr_en_now", 32'(wr_en), 32'd0);
    check_eq("rst_wr_valid_now", 32'(wr_valid), 32'd0);
    resp_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (resp_valid) resp_cnt++;
    end
    reset = 1'b0;
    rdy_bad = 0;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (resp_valid) resp_cnt++;
      if (!req_ready) rdy_bad++;
    end
    check_eq("rst_no_resp", 32'(resp_cnt), 32'd0);
    check_eq("rst_ready_after", 32'(rdy_bad), 32'd0);
    check_eq("rst_write_dropped", 32'(mem_v[0][3]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    clear_tables();
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset_rd_en", 32'(rd_en), 32'd0);
    check_eq("reset_wr_en", 32'(wr_en), 32'd0);
    check_eq("reset_resp_valid", 32'(resp_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check_eq("reset_ready", 32'(req_ready), 32'd1);
    check_eq("reset_hash_key", 32'(hash_key), 32'd0);
    check_eq("reset_wr_valid", 32'(wr_valid), 32'd0);

    // Empty tables: lands in table 0.
    hash_mode = 0; clear_tables();
    do_insert(2'd1, 4'd5, 0, 0);
    // Matching key in table 1 is overwritten.
    clear_tables();
    put(1, hfn(0, 1, 2'd2), 2'd2, 4'd3);
    do_insert(2'd2, 4'd9, 0, 0);
    // Tables 0 and 1 occupied by other keys, table 2 empty.
    clear_tables();
    put(0, hfn(0, 0, 2'd1), 2'd3, 4'd1);
    put(1, hfn(0, 1, 2'd1), 2'd0, 4'd2);
    do_insert(2'd1, 4'd4, 0, 0);
    // Every read full: four evictions then give up.
    hash_mode = 1; clear_tables();
    put(0, 0, 2'd0, 4'd1);
    put(1, 0, 2'd1, 4'd2);
    put(2, 0, 2'd2, 4'd3);
    do_insert(2'd3, 4'd6, 0, 0);
    // Enable low for three cycles during WAIT.
    hash_mode = 0; clear_tables();
    do_insert(2'd2, 4'hA, 2, 3);
    // Reset during WRITE.
    reset_in_write();

    // Randomized tables and requests across hash modes.
    for (int b = 0; b < 6; b++) begin
      hash_mode = int'($urandom_range(0, 2));
      clear_tables();
      for (int t = 0; t < T; t++)
        for (int a = 0; a < NA; a++)
          if ($urandom_range(0, 99) < 60) put(t, a, KW'($urandom), DW'($urandom));
      for (int i = 0; i < 6; i++)
        do_insert(KW'($urandom), DW'($urandom), 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
